// File: rtl/mem_port_arbiter.sv
// Arbitrates the IF and MEM pipeline stages onto one event-triggered 256-byte memory.
// Each grant becomes a SETUP / ACCESS / DONE sequence, so Enable only rises on stable inputs.
module mem_port_arbiter #(
    parameter int ADDR_LIMIT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    output logic        if_stall,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [1:0]  mem_size,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        mem_ack,
    output logic [31:0] mem_rdata,
    output logic        mem_stall,
    output logic        err,
    output logic        busy,
    output logic        ram_enable,
    output logic        ram_rw,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_din,
    output logic [1:0]  ram_size,
    input  logic [31:0] ram_dout
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    state_t      state, state_next;
    logic        grant_valid, pick_mem;
    logic        last_grant_mem;
    logic        lat_mem, lat_bad;
    logic [31:0] sel_addr, sel_wdata;
    logic [1:0]  sel_size;
    logic        sel_we, sel_bad;
    logic [1:0]  nbytes_m1;
    logic [9:0]  end_addr;
    logic [31:0] load_data;

    assign if_stall  = if_req & ~if_ack;
    assign mem_stall = mem_req & ~mem_ack;

    // Grant selection and access checking for the request seen in IDLE.
    // On a tie the port that did not win last time gets the memory.
    always_comb begin
        grant_valid = if_req | mem_req;
        pick_mem    = mem_req & (~if_req | ~last_grant_mem);
        sel_addr    = pick_mem ? mem_addr : if_addr;
        sel_size    = pick_mem ? mem_size : 2'b10;
        sel_we      = pick_mem & mem_we;
        sel_wdata   = pick_mem ? mem_wdata : 32'h0;

        case (sel_size)
            2'b00:   nbytes_m1 = 2'd0;
            2'b01:   nbytes_m1 = 2'd1;
            default: nbytes_m1 = 2'd3;
        endcase

        // High address bits are tested on their own so the end address never wraps.
        end_addr = {2'b00, sel_addr[7:0]} + {8'b0, nbytes_m1};
        sel_bad  = (sel_size == 2'b11)
                 | ((sel_size == 2'b01) & sel_addr[0])
                 | ((sel_size == 2'b10) & (sel_addr[1:0] != 2'b00))
                 | (sel_addr[31:8] != 24'h0)
                 | (end_addr > 10'(ADDR_LIMIT));
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_valid) state_next = SETUP;
            SETUP:   state_next = ACCESS;
            ACCESS:  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        case (ram_size)
            2'b00:   load_data = {24'h0, ram_dout[7:0]};
            2'b01:   load_data = {16'h0, ram_dout[15:0]};
            default: load_data = ram_dout;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Output registers change on the edge that enters each phase, so they line up with the state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant_mem <= 1'b0;
            lat_mem        <= 1'b0;
            lat_bad        <= 1'b0;
            ram_enable     <= 1'b0;
            ram_rw         <= 1'b0;
            ram_addr       <= 32'h0;
            ram_din        <= 32'h0;
            ram_size       <= 2'b00;
            if_ack         <= 1'b0;
            mem_ack        <= 1'b0;
            if_rdata       <= 32'h0;
            mem_rdata      <= 32'h0;
            err            <= 1'b0;
            busy           <= 1'b0;
        end else begin
            busy <= (state_next != IDLE);
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        lat_mem  <= pick_mem;
                        lat_bad  <= sel_bad;
                        ram_addr <= sel_addr;
                        ram_din  <= sel_wdata;
                        ram_size <= sel_size;
                        ram_rw   <= sel_we;
                    end
                end
                SETUP: begin
                    ram_enable <= ~lat_bad;
                end
                ACCESS: begin
                    ram_enable <= 1'b0;
                    err        <= lat_bad;
                    if (lat_mem) mem_ack <= 1'b1;
                    else         if_ack  <= 1'b1;
                    if (!lat_bad && !ram_rw) begin
                        if (lat_mem) mem_rdata <= load_data;
                        else         if_rdata  <= load_data;
                    end
                end
                DONE: begin
                    if_ack         <= 1'b0;
                    mem_ack        <= 1'b0;
                    err            <= 1'b0;
                    ram_rw         <= 1'b0;
                    last_grant_mem <= lat_mem;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: big-endian event-triggered memory model, fixed vectors,
// hand-written contention and reset sequences, then random accesses against a golden byte array.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        if_stall;
    logic        mem_req;
    logic        mem_we;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        mem_stall;
    logic        err;
    logic        busy;
    logic        ram_enable;
    logic        ram_rw;
    logic [31:0] ram_addr;
    logic [31:0] ram_din;
    logic [1:0]  ram_size;
    logic [31:0] ram_dout;

    logic [7:0]  ram  [256];
    logic [7:0]  gold [256];
    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_if_rdata;
    logic [31:0] exp_mem_rdata;

    typedef struct {
        bit          port_mem;
        bit          we;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        bit          exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs [15];

    mem_port_arbiter #(.ADDR_LIMIT(255)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata), .if_stall(if_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_stall(mem_stall),
        .err(err), .busy(busy),
        .ram_enable(ram_enable), .ram_rw(ram_rw), .ram_addr(ram_addr), .ram_din(ram_din),
        .ram_size(ram_size), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    // Memory acts on the rising edge of Enable; unused upper read bits carry junk on purpose.
    always @(posedge ram_enable) begin
        automatic int a = int'(ram_addr[7:0]);
        if (ram_rw) begin
            case (ram_size)
                2'b00: ram[a] = ram_din[7:0];
                2'b01: begin
                    ram[a]           = ram_din[15:8];
                    ram[(a + 1) % 256] = ram_din[7:0];
                end
                default: for (int k = 0; k < 4; k++) ram[(a + k) % 256] = ram_din[31 - 8 * k -: 8];
            endcase
        end else begin
            case (ram_size)
                2'b00:   ram_dout = {24'hABCDEF, ram[a]};
                2'b01:   ram_dout = {16'hBEAD, ram[a], ram[(a + 1) % 256]};
                default: ram_dout = {ram[a], ram[(a + 1) % 256], ram[(a + 2) % 256], ram[(a + 3) % 256]};
            endcase
        end
    end

    function automatic bit ref_bad(input logic [1:0] size, input logic [31:0] addr);
        longint nbytes;
        if (size == 2'b11) return 1'b1;
        nbytes = longint'(1) << size;
        if (longint'(addr) % nbytes != 0) return 1'b1;
        if (longint'(addr) + nbytes - 1 > 255) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_read(input logic [1:0] size, input logic [31:0] addr);
        logic [31:0] val = 32'h0;
        int nbytes = 1 << size;
        for (int k = 0; k < nbytes; k++) val = (val << 8) | {24'h0, gold[int'(addr[7:0]) + k]};
        return val;
    endfunction

    task automatic ref_write(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] data);
        int nbytes = 1 << size;
        for (int k = 0; k < nbytes; k++) begin
            logic [31:0] sh = data >> (8 * (nbytes - 1 - k));
            gold[int'(addr[7:0]) + k] = sh[7:0];
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One request on one port, followed from the request cycle to its ack.
    task automatic applyStimulus(input bit port_mem, input bit we, input logic [1:0] size,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input bit exp_err, input logic [31:0] exp_rdata, input string tag);
        int cyc = 0;
        bit got = 1'b0;
        int en_count = 0;
        int en_cyc = -1;
        bit stall_ok = 1'b1;
        @(negedge clk);
        if (port_mem) begin
            mem_req = 1'b1; mem_we = we; mem_size = size; mem_addr = addr; mem_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        while (cyc < 10) begin
            #1;
            if (port_mem ? mem_ack : if_ack) begin
                got = 1'b1;
                break;
            end
            if (!(port_mem ? mem_stall : if_stall)) stall_ok = 1'b0;
            if (ram_enable) begin
                en_count++;
                en_cyc = cyc;
            end
            @(negedge clk);
            cyc++;
        end
        checkOutput({tag, "_latency"}, got ? 32'(cyc) : 32'd99, 32'd3);
        checkOutput({tag, "_err"}, 32'(err), 32'(exp_err));
        checkOutput({tag, "_stall_before_ack"}, 32'(stall_ok), 32'd1);
        checkOutput({tag, "_stall_in_ack"}, 32'(port_mem ? mem_stall : if_stall), 32'd0);
        checkOutput({tag, "_enable_pulses"}, 32'(en_count), exp_err ? 32'd0 : 32'd1);
        if (!exp_err) checkOutput({tag, "_enable_cycle"}, 32'(en_cyc), 32'd2);
        checkOutput({tag, "_rdata"}, port_mem ? mem_rdata : if_rdata, exp_rdata);
        if_req  = 1'b0;
        mem_req = 1'b0;
    endtask

    initial begin
        logic [11:0] mem_ack_mask, if_ack_mask, if_stall_mask, mem_stall_mask;
        int diffs;

        rst_n = 1'b0;
        if_req = 1'b0; if_addr = 32'h0;
        mem_req = 1'b0; mem_we = 1'b0; mem_size = 2'b00; mem_addr = 32'h0; mem_wdata = 32'h0;
        ram_dout = 32'h0;
        for (int i = 0; i < 256; i++) begin
            ram[i]  = 8'h00;
            gold[i] = 8'h00;
        end
        ram[16'h10] = 8'hDE; ram[16'h11] = 8'hAD; ram[16'h12] = 8'hBE; ram[16'h13] = 8'hEF;
        gold[16'h10] = 8'hDE; gold[16'h11] = 8'hAD; gold[16'h12] = 8'hBE; gold[16'h13] = 8'hEF;

        repeat (2) @(negedge clk);
        #1;
        checkOutput("reset_ctrl", {24'h0, if_ack, mem_ack, err, busy, ram_enable, ram_rw, ram_size}, 32'h0);
        checkOutput("reset_if_rdata", if_rdata, 32'h0);
        checkOutput("reset_mem_rdata", mem_rdata, 32'h0);
        checkOutput("reset_ram_addr", ram_addr, 32'h0);
        checkOutput("reset_ram_din", ram_din, 32'h0);
        checkOutput("reset_stalls", {30'h0, if_stall, mem_stall}, 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("idle_no_request", {29'h0, busy, ram_enable, ram_rw}, 32'h0);

        vecs[0]  = '{1'b0, 1'b0, 2'b10, 32'h10,       32'h0,        1'b0, 32'hDEADBEEF};
        vecs[1]  = '{1'b1, 1'b1, 2'b01, 32'h22,       32'h0000A5C3, 1'b0, 32'h00000000};
        vecs[2]  = '{1'b1, 1'b0, 2'b00, 32'h23,       32'h0,        1'b0, 32'h000000C3};
        vecs[3]  = '{1'b1, 1'b0, 2'b01, 32'h22,       32'h0,        1'b0, 32'h0000A5C3};
        vecs[4]  = '{1'b1, 1'b1, 2'b10, 32'h41,       32'h11223344, 1'b1, 32'h0000A5C3};
        vecs[5]  = '{1'b1, 1'b0, 2'b01, 32'h13,       32'h0,        1'b1, 32'h0000A5C3};
        vecs[6]  = '{1'b1, 1'b0, 2'b11, 32'h20,       32'h0,        1'b1, 32'h0000A5C3};
        vecs[7]  = '{1'b1, 1'b1, 2'b10, 32'h100,      32'h55667788, 1'b1, 32'h0000A5C3};
        vecs[8]  = '{1'b1, 1'b1, 2'b00, 32'hFF,       32'h0000007F, 1'b0, 32'h0000A5C3};
        vecs[9]  = '{1'b1, 1'b0, 2'b10, 32'hFC,       32'h0,        1'b0, 32'h0000007F};
        vecs[10] = '{1'b1, 1'b0, 2'b00, 32'hFF,       32'h0,        1'b0, 32'h0000007F};
        vecs[11] = '{1'b0, 1'b0, 2'b10, 32'h20,       32'h0,        1'b0, 32'h0000A5C3};
        vecs[12] = '{1'b0, 1'b0, 2'b10, 32'hFFFFFFFC, 32'h0,        1'b1, 32'h0000A5C3};
        vecs[13] = '{1'b1, 1'b0, 2'b00, 32'hFFFFFF00, 32'h0,        1'b1, 32'h0000007F};
        vecs[14] = '{1'b1, 1'b0, 2'b01, 32'hFE,       32'h0,        1'b0, 32'h0000007F};

        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].port_mem, vecs[i].we, vecs[i].size, vecs[i].addr, vecs[i].wdata,
                          vecs[i].exp_err, vecs[i].exp_rdata, $sformatf("vec%0d", i));
            if (vecs[i].we && !vecs[i].exp_err) ref_write(vecs[i].size, vecs[i].addr, vecs[i].wdata);
        end

        // Reset during ACCESS of a store; the memory already saw Enable rise, so it took the write.
        @(negedge clk);
        mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'b10; mem_addr = 32'h30; mem_wdata = 32'hCAFEF00D;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("midrst_enable_in_access", 32'(ram_enable), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("midrst_no_ack", 32'(mem_ack), 32'd0);
        checkOutput("midrst_enable_low", 32'(ram_enable), 32'd0);
        checkOutput("midrst_busy_low", 32'(busy), 32'd0);
        checkOutput("midrst_rdata_cleared", mem_rdata, 32'h0);
        ref_write(2'b10, 32'h30, 32'hCAFEF00D);
        mem_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Both ports held high: MEM must win the first tie after reset, then grants alternate.
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'h10;
        mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'b00; mem_addr = 32'h23;
        mem_ack_mask = '0; if_ack_mask = '0; if_stall_mask = '0; mem_stall_mask = '0;
        for (int c = 0; c < 12; c++) begin
            #1;
            mem_ack_mask[c]   = mem_ack;
            if_ack_mask[c]    = if_ack;
            if_stall_mask[c]  = if_stall;
            mem_stall_mask[c] = mem_stall;
            if (c < 11) @(negedge clk);
        end
        if_req = 1'b0;
        mem_req = 1'b0;
        checkOutput("tie_mem_acks", {20'h0, mem_ack_mask}, 32'h808);
        checkOutput("tie_if_acks", {20'h0, if_ack_mask}, 32'h080);
        checkOutput("tie_if_stall", {20'h0, if_stall_mask}, 32'hF7F);
        checkOutput("tie_mem_stall", {20'h0, mem_stall_mask}, 32'h7F7);
        checkOutput("tie_if_rdata", if_rdata, 32'hDEADBEEF);
        checkOutput("tie_mem_rdata", mem_rdata, 32'h000000C3);
        exp_if_rdata  = 32'hDEADBEEF;
        exp_mem_rdata = 32'h000000C3;

        for (int i = 0; i < 40; i++) begin
            bit          pm, we, e;
            logic [1:0]  sz;
            logic [31:0] ad, wd, expd;
            int          nb;
            pm = 1'($urandom_range(0, 1));
            we = pm ? 1'($urandom_range(0, 1)) : 1'b0;
            sz = pm ? 2'($urandom_range(0, 3)) : 2'b10;
            nb = (sz == 2'b11) ? 4 : (1 << sz);
            if ($urandom_range(0, 9) == 0) ad = $urandom;
            else                           ad = 32'($urandom_range(0, 263));
            if ($urandom_range(0, 3) != 0) ad = ad & ~(32'(nb) - 32'd1);
            wd = $urandom;
            e  = ref_bad(sz, ad);
            if (!e && !we) begin
                if (pm) exp_mem_rdata = ref_read(sz, ad);
                else    exp_if_rdata  = ref_read(sz, ad);
            end
            expd = pm ? exp_mem_rdata : exp_if_rdata;
            applyStimulus(pm, we, sz, ad, wd, e, expd, $sformatf("rand%0d", i));
            if (we && !e) ref_write(sz, ad, wd);
        end

        diffs = 0;
        for (int i = 0; i < 256; i++) if (ram[i] !== gold[i]) diffs++;
        checkOutput("memory_contents_diff", 32'(diffs), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencer and arbiter that shares the single unified 256-byte memory between the IF stage (instruction fetch) and the MEM stage (load/store). It turns each granted request into a three-phase Enable/ReadWrite pulse sequence on the memory. The memory's `Enable`/`ReadWrite`/`Size` port is event-triggered, so address, data and size must be stable before `Enable` rises. The block also drives per-port acknowledge and stall signals consumed by the pipeline registers.

## Interface
- `ADDR_LIMIT`, default 255: highest valid byte address; any byte of the access beyond it is an error.
- `clk`  in  1  pipeline clock; all state changes on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low (sampled on rising `clk`).
- `if_req`  in  1  IF fetch request; held high until `if_ack`.
- `if_addr`  in  32  fetch byte address; stable while `if_req` high.
- `if_ack`  out  1  one-cycle pulse: fetch complete, `if_rdata` valid.
- `if_rdata`  out  32  fetched instruction word, held until next IF ack.
- `if_stall`  out  1  `if_req & ~if_ack` (combinational).
- `mem_req`  in  1  MEM stage request; held high until `mem_ack`.
- `mem_we`  in  1  1 = store, 0 = load.
- `mem_size`  in  2  00 byte, 01 half-word, 10 word, 11 invalid.
- `mem_addr`  in  32  data byte address.
- `mem_wdata`  in  32  store data (byte uses [7:0], half-word uses [15:0]).
- `mem_ack`  out  1  one-cycle pulse: access complete.
- `mem_rdata`  out  32  load data, zero-extended per size, held until next MEM load ack.
- `mem_stall`  out  1  `mem_req & ~mem_ack` (combinational).
- `err`  out  1  valid with either ack: access rejected, memory untouched.
- `busy`  out  1  high in every state except IDLE.
- `ram_enable`, `ram_rw`  out  1 each  to memory `Enable` and `ReadWrite`.
- `ram_addr`, `ram_din`  out  32 each  to memory `Address` and `DataIn`.
- `ram_size`  out  2  to memory `Size`.
- `ram_dout`  in  32  from memory `DataOut`.

## Operation
- FSM states: IDLE, SETUP, ACCESS, DONE.
- **IDLE**
  - No request: stay in IDLE; `ram_rw` is 0.
  - Exactly one request: grant it.
  - Both requests: grant the port not granted last. The `last_grant` register resets to IF, so MEM wins the first tie.
  - On grant:
    - Latch the port, addr, size, we and wdata into internal registers.
    - Compute `bad`.
    - Go to SETUP.
  - IF requests are always word reads.
- **`bad` conditions** (any one sets it):
  - `size==11`.
  - Half-word with `addr[0]=1`.
  - Word with `addr[1:0]!=0`.
  - `addr + bytes - 1 > ADDR_LIMIT`, computed without 32-bit overflow (test `addr[31:8]` first).
- **SETUP**
  - Drive `ram_addr`, `ram_din`, `ram_size` and `ram_rw` (= we) from the latched values.
  - `ram_enable` = 0.
  - Go to ACCESS.
- **ACCESS**
  - `ram_enable` = `~bad`; all other RAM outputs held.
  - Go to DONE.
- **DONE**
  - `ram_enable` = 0; `ram_rw` is still held, so the falling edge of Enable precedes any change of ReadWrite.
  - Pulse the granted port's ack; `err` = `bad`.
  - On a good read, capture `ram_dout` into that port's rdata register:
    - byte: `{24'b0, dout[7:0]}`
    - half-word: `{16'b0, dout[15:0]}`
    - word: full 32 bits.
  - Stores and errored accesses leave rdata unchanged.
  - Update `last_grant`; go to IDLE.
- **Request withdrawal:** a requester dropping `req` before ack is illegal. The latched values are still used and the ack is still issued.
- **`rst_n` low** at any edge, including mid-access:
  - Next state is IDLE; the transaction is abandoned with no ack.
  - `last_grant` returns to IF.

## Timing
- Reset values: every output register is 0 (`ram_enable`, `ram_rw`, `ram_addr`, `ram_din`, `ram_size`, `if_ack`, `mem_ack`, `if_rdata`, `mem_rdata`, `err`, `busy`).
- Latency: request seen high in IDLE at edge T; ack high in cycle T+3 (IDLE→SETUP→ACCESS→DONE).
- Throughput: one access per 4 cycles. The cycle after ack is IDLE, and a `req` still high there is a new request.
- `ram_enable` is high for exactly one cycle per good access. Addr, size, din and rw are stable one cycle before and one cycle after that high cycle.
- `if_stall`/`mem_stall` are high from the first request cycle through the cycle before ack, and low in the ack cycle.
- Errored access: same 4-cycle timing, `ram_enable` never asserted.

## Test plan
- **Reset:** hold `rst_n`=0 for 2 cycles → all outputs 0, `busy`=0. Release; no request → remains IDLE.
- **IF word fetch:** memory[0x10..0x13]=DE AD BE EF, `if_req` with addr 0x10 → `ram_enable` pulses once in cycle T+2; `if_ack` at T+3 with `if_rdata`=0xDEADBEEF, `err`=0; `if_stall` high T..T+2.
- **Store then load:** store half-word 0xA5C3 to 0x22, then load byte from 0x23 → `mem_rdata`=0x000000C3. Also load half-word from 0x22 → 0x0000A5C3.
- **Contention:** `if_req` and `mem_req` rise together and stay high → MEM acked at T+3, IF acked at T+7, and `if_stall` high throughout. Repeat with both high → grants alternate MEM, IF, MEM.
- **Error cases:** word at 0x41, half-word at 0x13, size 11, word at 0x100 → each acks at T+3 with `err`=1, `ram_enable` never high, and memory contents unchanged.
- **Reset mid-access:** assert `rst_n`=0 during ACCESS of a store to 0x30 → no ack and `ram_enable` 0 next cycle. After release, a fresh tie is won by MEM.
